// File: rtl/store_unit_if.sv
// -----------------------------------------------------------------------------
// store_unit_if : request/memory bus bundle for store_unit
//   Request side : I_req, I_storesel, I_addr, I_data -> O_busy, O_done, O_fault
//   Memory side  : O_mem_addr, O_mem_wdata, O_mem_be, O_mem_we, O_mem_re
//                  <- I_mem_rdata, I_mem_ack
//   slave  modport : store_unit view (drives O_*)
//   master modport : requester / memory model view (drives I_*)
// -----------------------------------------------------------------------------
interface store_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic                I_req;
   logic [1:0]          I_storesel;
   logic [ADDR_W-1:0]   I_addr;
   logic [31:0]         I_data;
   logic                O_busy;
   logic                O_done;
   logic                O_fault;
   logic [ADDR_W-1:0]   O_mem_addr;
   logic [31:0]         O_mem_wdata;
   logic [3:0]          O_mem_be;
   logic                O_mem_we;
   logic                O_mem_re;
   logic [31:0]         I_mem_rdata;
   logic                I_mem_ack;

   modport slave (
      input  I_req, I_storesel, I_addr, I_data, I_mem_rdata, I_mem_ack,
      output O_busy, O_done, O_fault, O_mem_addr, O_mem_wdata, O_mem_be,
             O_mem_we, O_mem_re
   );

   modport master (
      output I_req, I_storesel, I_addr, I_data, I_mem_rdata, I_mem_ack,
      input  O_busy, O_done, O_fault, O_mem_addr, O_mem_wdata, O_mem_be,
             O_mem_we, O_mem_re
   );
endinterface

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit : SB/SH/SW store engine with lane alignment and misalign faulting
//   I_clk   : clock, all state on rising edge
//   I_rstn  : asynchronous active-low reset
//   sif     : store_unit_if.slave (request handshake + memory strobe bus)
// Optional feature macro STORE_RMW_EN: read-modify-write for partial stores
// to memories without byte enables (READ state, O_mem_re, merged wdata,
// O_mem_be forced to 1111 on write). Undefined: O_mem_re is tied 0.
// -----------------------------------------------------------------------------
module store_unit #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic          I_clk,
   input  logic          I_rstn,
   store_unit_if.slave   sif
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned ST_W   = 3;

   typedef enum logic [ST_W-1:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_DONE  = 3'd2,
      S_FAULT = 3'd3
`ifdef STORE_RMW_EN
      , S_READ = 3'd4
`endif
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                w_accept;
   logic                w_req_fault;
   logic [BE_W-1:0]     w_req_be;
   logic [DATA_W-1:0]   w_req_wdata;
   logic [ADDR_W-1:0]   w_req_maddr;

   logic                w_busy_nxt;
   logic                w_we_nxt;
   logic                w_done_nxt;
   logic                w_fault_nxt;

   logic                r_busy;
   logic                r_we;
   logic                r_done;
   logic                r_fault;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [BE_W-1:0]     r_mem_be;

`ifdef STORE_RMW_EN
   logic                w_re_nxt;
   logic                r_re;

   // Enabled lanes from the new data, remaining lanes from the read word
   function automatic logic [DATA_W-1:0] merge_lanes(
      input logic [DATA_W-1:0] new_w,
      input logic [DATA_W-1:0] old_w,
      input logic [BE_W-1:0]   be
   );
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(BE_W); i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction
`else
   logic                w_unused_rdata;
   assign w_unused_rdata = ^sif.I_mem_rdata;
`endif

   assign w_accept = (r_state == S_IDLE) && sif.I_req;

   // Misaligned halfword/word and the reserved encoding are rejected
   assign w_req_fault = (sif.I_storesel == 2'b11)
                     || ((sif.I_storesel == 2'b01) && sif.I_addr[0])
                     || ((sif.I_storesel == 2'b10) && (sif.I_addr[1:0] != 2'b00));

   assign w_req_maddr = {sif.I_addr[ADDR_W-1:2], 2'b00};

   // Lane enables and replicated write data for the incoming request
   always_comb begin
      w_req_be    = '0;
      w_req_wdata = '0;
      case (sif.I_storesel)
         2'b00: begin
            w_req_be    = BE_W'(4'b0001 << sif.I_addr[1:0]);
            w_req_wdata = {4{sif.I_data[7:0]}};
         end
         2'b01: begin
            w_req_be    = sif.I_addr[1] ? 4'b1100 : 4'b0011;
            w_req_wdata = {2{sif.I_data[15:0]}};
         end
         2'b10: begin
            w_req_be    = 4'b1111;
            w_req_wdata = sif.I_data;
         end
         default: begin
            w_req_be    = '0;
            w_req_wdata = '0;
         end
      endcase
   end

   // State register
   always_ff @(posedge I_clk or negedge I_rstn) begin
      if (!I_rstn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (sif.I_req) begin
               if (w_req_fault) begin
                  w_state_nxt = S_FAULT;
`ifdef STORE_RMW_EN
               end else if (w_req_be != 4'b1111) begin
                  w_state_nxt = S_READ;
`endif
               end else begin
                  w_state_nxt = S_WRITE;
               end
            end
         end
`ifdef STORE_RMW_EN
         S_READ:  if (sif.I_mem_ack) w_state_nxt = S_WRITE;
`endif
         S_WRITE: if (sif.I_mem_ack) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         S_FAULT: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so strobes are registered
   always_comb begin
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_we_nxt    = (w_state_nxt == S_WRITE);
      w_done_nxt  = (w_state_nxt == S_DONE);
      w_fault_nxt = (w_state_nxt == S_FAULT);
`ifdef STORE_RMW_EN
      w_re_nxt    = (w_state_nxt == S_READ);
`endif
   end

   // Output and datapath registers
   always_ff @(posedge I_clk or negedge I_rstn) begin
      if (!I_rstn) begin
         r_busy      <= 1'b0;
         r_we        <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
`ifdef STORE_RMW_EN
         r_re        <= 1'b0;
`endif
      end else begin
         r_busy  <= w_busy_nxt;
         r_we    <= w_we_nxt;
         r_done  <= w_done_nxt;
         r_fault <= w_fault_nxt;
`ifdef STORE_RMW_EN
         r_re    <= w_re_nxt;
`endif
         if (w_accept && !w_req_fault) begin
            r_mem_addr  <= w_req_maddr;
            r_mem_wdata <= w_req_wdata;
            r_mem_be    <= w_req_be;
         end
`ifdef STORE_RMW_EN
         // Captured read word fills the lanes the store does not touch
         if ((r_state == S_READ) && sif.I_mem_ack) begin
            r_mem_wdata <= merge_lanes(r_mem_wdata, sif.I_mem_rdata, r_mem_be);
            r_mem_be    <= 4'b1111;
         end
`endif
      end
   end

   assign sif.O_busy      = r_busy;
   assign sif.O_done      = r_done;
   assign sif.O_fault     = r_fault;
   assign sif.O_mem_we    = r_we;
   assign sif.O_mem_addr  = r_mem_addr;
   assign sif.O_mem_wdata = r_mem_wdata;
   assign sif.O_mem_be    = r_mem_be;
`ifdef STORE_RMW_EN
   assign sif.O_mem_re    = r_re;
`else
   assign sif.O_mem_re    = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit : directed vector bench for store_unit
//   Table of stores with hand-computed lanes/enables, plus hand sequences for
//   mid-transaction reset, request held during busy and stray acknowledges.
//   Builds with or without STORE_RMW_EN; expectations follow the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_store_unit;
   localparam int unsigned ADDR_W = 32;
`ifdef STORE_RMW_EN
   localparam bit RMW = 1'b1;
`else
   localparam bit RMW = 1'b0;
`endif

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
      int          delay;
      bit          fault;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] wd_rmw;
      logic [31:0] maddr;
   } vec_t;

   logic I_clk;
   logic I_rstn;
   int   n_tests;
   int   n_fail;

   store_unit_if #(.ADDR_W(ADDR_W)) sif ();

   store_unit #(.ADDR_W(ADDR_W)) dut (
      .I_clk  (I_clk),
      .I_rstn (I_rstn),
      .sif    (sif)
   );

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request (caller is at posedge+1 with DUT idle) and observe it
   task automatic run_vec(input vec_t v, input string tag);
      int we_cnt, re_cnt, done_cnt, fault_cnt, done_cyc, fault_cyc, overlap;
      logic [3:0]  got_be;
      logic [31:0] got_wd, got_ma;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      int          exp_re;
      we_cnt = 0; re_cnt = 0; done_cnt = 0; fault_cnt = 0;
      done_cyc = -1; fault_cyc = -1; overlap = 0;
      got_be = '0; got_wd = '0; got_ma = '0;

      sif.I_req      = 1'b1;
      sif.I_storesel = v.sel;
      sif.I_addr     = v.addr;
      sif.I_data     = v.data;
      sif.I_mem_ack  = 1'b0;
      @(posedge I_clk); #1;
      sif.I_req = 1'b0;
      check({tag, " busy_after_accept"}, 32'(sif.O_busy), 32'd1);

      for (int c = 1; c <= v.delay + 8; c++) begin
         sif.I_mem_ack = sif.O_mem_re || (sif.O_mem_we && (we_cnt == v.delay));
         @(negedge I_clk);
         if (sif.O_mem_we && sif.O_mem_re) overlap++;
         if (sif.O_mem_we) begin
            if (we_cnt == 0) begin
               got_be = sif.O_mem_be;
               got_wd = sif.O_mem_wdata;
               got_ma = sif.O_mem_addr;
            end
            we_cnt++;
         end
         if (sif.O_mem_re) re_cnt++;
         if (sif.O_done) begin done_cnt++; done_cyc = c; end
         if (sif.O_fault) begin fault_cnt++; fault_cyc = c; end
         @(posedge I_clk); #1;
      end
      sif.I_mem_ack = 1'b0;

      exp_be = RMW ? 4'hF : v.be;
      exp_wd = RMW ? v.wd_rmw : v.wd;
      exp_re = (RMW && (v.be != 4'hF)) ? 1 : 0;

      check({tag, " we_re_overlap"}, 32'(overlap), 32'd0);
      check({tag, " busy_end"}, 32'(sif.O_busy), 32'd0);
      if (v.fault) begin
         check({tag, " fault_cnt"}, 32'(fault_cnt), 32'd1);
         check({tag, " fault_cyc"}, 32'(fault_cyc), 32'd1);
         check({tag, " we_cnt"},    32'(we_cnt),    32'd0);
         check({tag, " re_cnt"},    32'(re_cnt),    32'd0);
         check({tag, " done_cnt"},  32'(done_cnt),  32'd0);
      end else begin
         check({tag, " fault_cnt"}, 32'(fault_cnt), 32'd0);
         check({tag, " we_cnt"},    32'(we_cnt),    32'(v.delay + 1));
         check({tag, " re_cnt"},    32'(re_cnt),    32'(exp_re));
         check({tag, " done_cnt"},  32'(done_cnt),  32'd1);
         check({tag, " done_cyc"},  32'(done_cyc),  32'(v.delay + 2 + exp_re));
         check({tag, " be"},        32'(got_be),    32'(exp_be));
         check({tag, " wdata"},     got_wd,         exp_wd);
         check({tag, " mem_addr"},  got_ma,         v.maddr);
      end
   endtask

   vec_t vecs[11];
   vec_t v_after;

   initial begin
      int we_cnt, done_cnt;
      n_tests = 0;
      n_fail  = 0;

      //            sel    addr          data          dly flt be       wd            wd_rmw        maddr
      vecs[0]  = '{2'b00, 32'h0000_1003, 32'hAABBCCDD, 0, 1'b0, 4'b1000, 32'hDDDDDDDD, 32'hDD223344, 32'h0000_1000};
      vecs[1]  = '{2'b01, 32'h0000_2002, 32'h00001234, 3, 1'b0, 4'b1100, 32'h12341234, 32'h12343344, 32'h0000_2000};
      vecs[2]  = '{2'b10, 32'h0000_3001, 32'h01020304, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
      vecs[3]  = '{2'b11, 32'h0000_0000, 32'h01020304, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
      vecs[4]  = '{2'b00, 32'h0000_5000, 32'h000000A5, 1, 1'b0, 4'b0001, 32'hA5A5A5A5, 32'h112233A5, 32'h0000_5000};
      vecs[5]  = '{2'b01, 32'h0000_6000, 32'hFFFF8001, 0, 1'b0, 4'b0011, 32'h80018001, 32'h11228001, 32'h0000_6000};
      vecs[6]  = '{2'b10, 32'h0000_7004, 32'hDEADBEEF, 2, 1'b0, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_7004};
      vecs[7]  = '{2'b01, 32'h0000_6001, 32'h0000FFFF, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0};
      vecs[8]  = '{2'b00, 32'h0000_8002, 32'h12345677, 0, 1'b0, 4'b0100, 32'h77777777, 32'h11773344, 32'h0000_8000};
      vecs[9]  = '{2'b00, 32'h0000_4001, 32'h00000055, 0, 1'b0, 4'b0010, 32'h55555555, 32'h11225544, 32'h0000_4000};
      vecs[10] = '{2'b10, 32'hFFFF_FFFC, 32'h89ABCDEF, 1, 1'b0, 4'b1111, 32'h89ABCDEF, 32'h89ABCDEF, 32'hFFFF_FFFC};
      v_after  = '{2'b10, 32'h0000_B000, 32'h0BADF00D, 0, 1'b0, 4'b1111, 32'h0BADF00D, 32'h0BADF00D, 32'h0000_B000};

      sif.I_req       = 1'b0;
      sif.I_storesel  = 2'b00;
      sif.I_addr      = '0;
      sif.I_data      = '0;
      sif.I_mem_ack   = 1'b0;
      sif.I_mem_rdata = 32'h11223344;
      I_rstn          = 1'b0;

      // Reset state
      repeat (3) @(negedge I_clk);
      check("rst busy",  32'(sif.O_busy),   32'd0);
      check("rst we_re", 32'({sif.O_mem_we, sif.O_mem_re}), 32'd0);
      check("rst done_fault", 32'({sif.O_done, sif.O_fault}), 32'd0);
      check("rst be",    32'(sif.O_mem_be), 32'd0);
      check("rst wdata", sif.O_mem_wdata,   32'd0);
      check("rst addr",  sif.O_mem_addr,    32'd0);
      I_rstn = 1'b1;
      @(posedge I_clk); #1;

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // Reset asserted while the write strobe waits for an acknowledge
      sif.I_req      = 1'b1;
      sif.I_storesel = 2'b10;
      sif.I_addr     = 32'h0000_9000;
      sif.I_data     = 32'hCAFEF00D;
      @(posedge I_clk); #1;
      sif.I_req = 1'b0;
      @(posedge I_clk); #1;
      check("midrst we_before", 32'(sif.O_mem_we), 32'd1);
      #2 I_rstn = 1'b0;
      #1;
      check("midrst busy",  32'(sif.O_busy),   32'd0);
      check("midrst we",    32'(sif.O_mem_we), 32'd0);
      check("midrst be",    32'(sif.O_mem_be), 32'd0);
      check("midrst wdata", sif.O_mem_wdata,   32'd0);
      check("midrst addr",  sif.O_mem_addr,    32'd0);
      @(negedge I_clk);
      I_rstn = 1'b1;
      @(posedge I_clk); #1;
      we_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge I_clk);
         if (sif.O_mem_we || sif.O_busy) we_cnt++;
         @(posedge I_clk); #1;
      end
      check("midrst no_resume", 32'(we_cnt), 32'd0);
      run_vec(v_after, "post_rst");

      // Request held high through busy: one store per accept, nothing queued
      sif.I_req      = 1'b1;
      sif.I_storesel = 2'b10;
      sif.I_addr     = 32'h0000_A000;
      sif.I_data     = 32'h00000001;
      we_cnt   = 0;
      done_cnt = 0;
      for (int c = 0; c < 13; c++) begin
         if (c == 9) sif.I_req = 1'b0;
         sif.I_mem_ack = sif.O_mem_we;
         @(negedge I_clk);
         if (sif.O_mem_we) we_cnt++;
         if (sif.O_done)   done_cnt++;
         @(posedge I_clk); #1;
      end
      sif.I_mem_ack = 1'b0;
      check("hold we_cnt",   32'(we_cnt),   32'd3);
      check("hold done_cnt", 32'(done_cnt), 32'd3);
      check("hold busy_end", 32'(sif.O_busy), 32'd0);

      // Stray acknowledge while idle must not start anything
      sif.I_mem_ack = 1'b1;
      we_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge I_clk);
         if (sif.O_busy || sif.O_done || sif.O_mem_we || sif.O_fault) we_cnt++;
         @(posedge I_clk); #1;
      end
      sif.I_mem_ack = 1'b0;
      check("idle_ack ignored", 32'(we_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
